// File: rtl/exec_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : exec_unit_mc
// Brief    : Multi-cycle execute stage: 1-cycle ALU, pipelined MUL, iterative
//            restoring DIV/REM, 4-bit flags. Optional macro
//            EXEC_MC_SIGNED_DIV_EN adds signed DIVS/REMS (ops 9/10).
// Revision : 1.0 - initial release
// ============================================================================
module exec_unit_mc #(
    parameter int W_OPR      = 32,
    parameter int W_RD       = 5,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    output logic             stall_o,
    input  logic [3:0]       op_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic             wb_en_i,
    input  logic             stall_i,
    output logic             v_o,
    output logic [W_OPR-1:0] result_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic             wb_o,
    output logic [3:0]       flags_o,
    output logic             busy_o
);

`ifdef EXEC_MC_SIGNED_DIV_EN
    localparam bit C_SDIV_EN = 1'b1;
`else
    localparam bit C_SDIV_EN = 1'b0;
`endif

    localparam logic [3:0] C_OP_ADD  = 4'd0;
    localparam logic [3:0] C_OP_SUB  = 4'd1;
    localparam logic [3:0] C_OP_MUL  = 4'd2;
    localparam logic [3:0] C_OP_DIVU = 4'd3;
    localparam logic [3:0] C_OP_REMU = 4'd4;
    localparam logic [3:0] C_OP_AND  = 4'd5;
    localparam logic [3:0] C_OP_OR   = 4'd6;
    localparam logic [3:0] C_OP_XOR  = 4'd7;
    localparam logic [3:0] C_OP_CMP  = 4'd8;
    localparam logic [3:0] C_OP_DIVS = 4'd9;
    localparam logic [3:0] C_OP_REMS = 4'd10;
    localparam logic [3:0] C_OP_NOP  = 4'd15;

    localparam int C_CNT_MAX = (W_OPR > MUL_STAGES) ? W_OPR : MUL_STAGES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam logic [C_CNT_W-1:0] C_MUL_LAST  = C_CNT_W'(MUL_STAGES - 1);
    localparam logic [C_CNT_W-1:0] C_UDIV_LAST = C_CNT_W'(W_OPR - 1);
    localparam logic [C_CNT_W-1:0] C_SDIV_LAST = C_CNT_W'(W_OPR);
    localparam logic [W_OPR-1:0]   C_MOST_NEG  = {1'b1, {(W_OPR-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [W_OPR-1:0]   a_q, a_d;
    logic [W_OPR-1:0]   b_q, b_d;
    logic [W_OPR-1:0]   rem_q, rem_d;
    logic [3:0]         op_q, op_d;
    logic [W_RD-1:0]    in_rd_q, in_rd_d;
    logic               wen_q, wen_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               sovf_q, sovf_d;

    logic               v_q;
    logic [W_OPR-1:0]   res_q;
    logic [W_RD-1:0]    out_rd_q;
    logic               wb_q;
    logic [3:0]         flags_q;

    logic               w_hold;
    logic               w_acc;
    logic [3:0]         w_op_eff;
    logic [W_OPR:0]     w_sum;
    logic [W_OPR:0]     w_diff;
    logic [2*W_OPR-1:0] w_prod;
    logic [W_OPR:0]     w_trial;
    logic               w_qbit;
    logic [W_OPR-1:0]   w_rem_nx;
    logic [W_OPR-1:0]   w_quo_nx;
    logic [W_OPR-1:0]   w_a_mag;
    logic [W_OPR-1:0]   w_b_mag;
    logic               w_in_sdiv;
    logic               w_lat_sdiv;
    logic               w_lat_rem;

    logic               w_done;
    logic               w_cmp;
    logic               w_keep;
    logic [W_OPR-1:0]   w_res;
    logic [W_OPR-1:0]   w_zs;
    logic               w_carry;
    logic               w_ovf;
    logic               w_wb;
    logic [W_RD-1:0]    w_wbr;
    logic [3:0]         w_flags;

    assign w_hold  = v_q & stall_i;
    assign busy_o  = (state_q != S_IDLE);
    assign stall_o = busy_o | w_hold;
    assign w_acc   = v_i & ~stall_o;

    always_comb begin
        w_op_eff = op_i;
        if (!C_SDIV_EN && (op_i == C_OP_DIVS || op_i == C_OP_REMS)) begin
            w_op_eff = C_OP_NOP;
        end
    end

    assign w_sum  = {1'b0, opr0_i} + {1'b0, opr1_i};
    assign w_diff = {1'b0, opr0_i} - {1'b0, opr1_i};
    assign w_prod = {{W_OPR{1'b0}}, a_q} * {{W_OPR{1'b0}}, b_q};

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_trial  = {rem_q, a_q[W_OPR-1]} - {1'b0, b_q};
    assign w_qbit   = ~w_trial[W_OPR];
    assign w_rem_nx = w_qbit ? w_trial[W_OPR-1:0] : {rem_q[W_OPR-2:0], a_q[W_OPR-1]};
    assign w_quo_nx = {a_q[W_OPR-2:0], w_qbit};

    assign w_a_mag    = opr0_i[W_OPR-1] ? (~opr0_i + 1'b1) : opr0_i;
    assign w_b_mag    = opr1_i[W_OPR-1] ? (~opr1_i + 1'b1) : opr1_i;
    assign w_in_sdiv  = (w_op_eff == C_OP_DIVS) || (w_op_eff == C_OP_REMS);
    assign w_lat_sdiv = (op_q == C_OP_DIVS) || (op_q == C_OP_REMS);
    assign w_lat_rem  = (op_q == C_OP_REMU) || (op_q == C_OP_REMS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        op_d    = op_q;
        in_rd_d = in_rd_q;
        wen_d   = wen_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        sovf_d  = sovf_q;
        w_done  = 1'b0;
        w_cmp   = 1'b0;
        w_keep  = 1'b0;
        w_res   = '0;
        w_zs    = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_wb    = wen_q & (op_q != C_OP_CMP);
        w_wbr   = in_rd_q;

        case (state_q)
            S_IDLE: begin
                if (w_acc) begin
                    op_d    = w_op_eff;
                    in_rd_d = wb_r_i;
                    wen_d   = wb_en_i;
                    cnt_d   = '0;
                    if (w_op_eff == C_OP_MUL) begin
                        a_d     = opr0_i;
                        b_d     = opr1_i;
                        state_d = S_MUL;
                    end else if ((w_op_eff == C_OP_DIVU || w_op_eff == C_OP_REMU || w_in_sdiv)
                                 && (opr1_i != '0)) begin
                        a_d     = w_in_sdiv ? w_a_mag : opr0_i;
                        b_d     = w_in_sdiv ? w_b_mag : opr1_i;
                        rem_d   = '0;
                        qneg_d  = w_in_sdiv & (opr0_i[W_OPR-1] ^ opr1_i[W_OPR-1]);
                        rneg_d  = w_in_sdiv & opr0_i[W_OPR-1];
                        sovf_d  = w_in_sdiv & (opr0_i == C_MOST_NEG) & (&opr1_i);
                        state_d = S_DIV;
                    end else begin
                        w_done = 1'b1;
                        w_wb   = wb_en_i & (w_op_eff != C_OP_CMP);
                        w_wbr  = wb_r_i;
                        case (w_op_eff)
                            C_OP_ADD: begin
                                w_res   = w_sum[W_OPR-1:0];
                                w_carry = w_sum[W_OPR];
                                w_ovf   = (opr0_i[W_OPR-1] == opr1_i[W_OPR-1]) &&
                                          (w_sum[W_OPR-1] != opr0_i[W_OPR-1]);
                            end
                            C_OP_SUB, C_OP_CMP: begin
                                w_res   = (w_op_eff == C_OP_CMP) ? '0 : w_diff[W_OPR-1:0];
                                w_cmp   = (w_op_eff == C_OP_CMP);
                                w_zs    = w_diff[W_OPR-1:0];
                                w_carry = w_diff[W_OPR];
                                w_ovf   = (opr0_i[W_OPR-1] != opr1_i[W_OPR-1]) &&
                                          (w_diff[W_OPR-1] != opr0_i[W_OPR-1]);
                            end
                            // Only divide-by-zero reaches these two arms.
                            C_OP_DIVU, C_OP_DIVS: begin
                                w_res = '1;
                                w_ovf = 1'b1;
                            end
                            C_OP_REMU, C_OP_REMS: begin
                                w_res = opr0_i;
                                w_ovf = 1'b1;
                            end
                            C_OP_AND: w_res = opr0_i & opr1_i;
                            C_OP_OR:  w_res = opr0_i | opr1_i;
                            C_OP_XOR: w_res = opr0_i ^ opr1_i;
                            default:  w_keep = 1'b1;
                        endcase
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == C_MUL_LAST) begin
                    w_done  = 1'b1;
                    w_res   = w_prod[W_OPR-1:0];
                    w_carry = |w_prod[2*W_OPR-1:W_OPR];
                    if (!w_hold) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                if (w_lat_sdiv && cnt_q == C_SDIV_LAST) begin
                    w_done = 1'b1;
                    w_ovf  = sovf_q;
                    if (w_lat_rem) begin
                        w_res = rneg_q ? (~rem_q + 1'b1) : rem_q;
                    end else begin
                        w_res = qneg_q ? (~a_q + 1'b1) : a_q;
                    end
                end else if (!w_lat_sdiv && cnt_q == C_UDIV_LAST) begin
                    w_done = 1'b1;
                    w_res  = w_lat_rem ? w_rem_nx : w_quo_nx;
                end else begin
                    a_d   = w_quo_nx;
                    rem_d = w_rem_nx;
                    cnt_d = cnt_q + 1'b1;
                end
                if (w_done && !w_hold) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!w_cmp) begin
            w_zs = w_res;
        end
    end

    assign w_flags = {w_ovf, w_zs[W_OPR-1], ~|w_zs, w_carry};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            in_rd_q <= '0;
            wen_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            sovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            in_rd_q <= in_rd_d;
            wen_q   <= wen_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            sovf_q  <= sovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q      <= 1'b0;
            res_q    <= '0;
            out_rd_q <= '0;
            wb_q     <= 1'b0;
            flags_q  <= '0;
        end else if (!w_hold) begin
            v_q <= w_done;
            if (w_done) begin
                res_q    <= w_res;
                out_rd_q <= w_wbr;
                wb_q     <= w_wb;
                if (!w_keep) begin
                    flags_q <= w_flags;
                end
            end
        end
    end

    assign v_o      = v_q;
    assign result_o = res_q;
    assign wb_r_o   = out_rd_q;
    assign wb_o     = v_q & wb_q;
    assign flags_o  = flags_q;

endmodule
`default_nettype wire

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle execute stage.
- Executes single-cycle ALU ops, pipelined multiply and iterative restoring divide on W_OPR-bit operands.
- Keeps a 4-bit flags register and presents one registered result per instruction to writeback.
- Sits between decode and writeback; back-pressures decode via stall_o.

Parameters:
- W_OPR, 32, operand/result width (>=8).
- W_RD, 5, writeback register index width.
- MUL_STAGES, 2, multiply pipeline depth (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- v_i  in  1  instruction valid from decode.
- stall_o  out  1  unit cannot accept; decode holds its inputs.
- op_i  in  4  operation code (see Behaviour).
- opr0_i  in  W_OPR  operand A / dividend.
- opr1_i  in  W_OPR  operand B / divisor.
- wb_r_i  in  W_RD  destination register.
- wb_en_i  in  1  instruction writes a register.
- stall_i  in  1  downstream cannot take result.
- v_o  out  1  result valid.
- result_o  out  W_OPR  result.
- wb_r_o  out  W_RD  destination.
- wb_o  out  1  v_o & registered wb_en.
- flags_o  out  4  [0] carry, [1] zero, [2] sign, [3] overflow.
- busy_o  out  1  MUL or DIV in progress.

Behaviour:
- Op codes: 0 ADD, 1 SUB, 2 MUL (low W_OPR bits), 3 DIVU, 4 REMU, 5 AND, 6 OR, 7 XOR, 8 CMP (SUB flags only; wb forced 0). 9/10 are gated by the optional feature. 11-15 NOP: result 0, flags unchanged.
- Accept condition: v_i & ~stall_o.
- stall_o = busy_o | (v_o & stall_i).
- Output register:
  - Holds result_o, wb_r_o, wb_o, v_o and flags_o while v_o & stall_i.
  - Otherwise loads on completion; v_o clears when nothing completes.
- FSM states IDLE, MUL, DIV.
  - IDLE: single-cycle op accepted -> output loads next edge (latency 1). MUL accepted -> MUL. DIV/REM accepted -> DIV.
  - MUL: counter runs MUL_STAGES cycles; v_o rises exactly MUL_STAGES+1 edges after accept; -> IDLE.
  - DIV: one quotient bit per cycle, MSB first, W_OPR iterations; v_o rises W_OPR+1 edges after accept; -> IDLE.
  - Operands, op, wb_r and wb_en are latched at accept. Inputs may change afterwards.
  - If a MUL/DIV finishes while the output is stalled, the FSM waits in its final state with the result held internally and busy_o=1 until the output frees.
- Divide by zero: completes in 1 cycle without entering DIV. Quotient = all ones, remainder = opr0. Flag overflow=1.
- Flags load together with the result:
  - ADD/SUB/CMP: carry = carry-out (SUB: borrow), overflow = signed overflow.
  - MUL: carry = high product bits nonzero, overflow = 0.
  - Logic and DIV ops: carry = overflow = 0, except overflow on divide by zero.
  - zero = (result==0); sign = result MSB.
  - CMP: flags from A-B; result_o = 0; wb_o = 0.
- Reset, including mid-MUL/DIV: all outputs 0, FSM to IDLE, in-flight op discarded, flags 0.

Optional Feature:
- Macro: EXEC_MC_SIGNED_DIV_EN.
- Defined: op 9 DIVS and op 10 REMS, signed truncating division.
  - Magnitudes are divided on the unsigned datapath; quotient/remainder signs are fixed up in the final cycle, adding 1 cycle of latency (W_OPR+2).
  - Most-negative / -1: quotient = most-negative, remainder 0, overflow=1.
- Undefined: ops 9/10 behave as NOP.

Test Plan:
- ADD 0xFFFFFFFF+1 (W_OPR=32) -> v_o one cycle later, result 0, flags carry=1, zero=1, sign=0, overflow=0.
- MUL 0x10000 * 0x10000, MUL_STAGES=2 -> stall_o high 2 cycles, v_o at accept+3, result 0, carry=1; a v_i held meanwhile is accepted exactly once.
- DIVU 100/7 then REMU 100/7 -> results 14 and 2, each valid at accept+33; no second accept while busy_o.
- DIVU 5/0 -> result 0xFFFFFFFF at accept+1, overflow=1. REMU 5/0 -> result 5.
- Hold stall_i=1 for 5 cycles while DIV completes -> result_o stable; stall_o=1; on release, exactly one v_o pulse with quotient intact.
- Assert reset 10 cycles into DIV -> v_o=0, busy_o=0, flags 0 immediately. Next ADD 2+3 after deassert -> 5.
